// File: rtl/ufm_shadow_pkg.sv
// Shared types and constants for the UFM shadow byte streamer.
package ufm_shadow_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
    localparam int unsigned CSUM_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_COPY = 2'd1,
        ST_STREAM    = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

    localparam byte_idx_t LAST_BYTE = byte_idx_t'(BYTES_PER_WORD - 1);

    // One beat of the outgoing byte stream.
    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } byte_beat_t;

    // Little-endian lane select: lane 0 is word[7:0].
    function automatic logic [BYTE_W-1:0] word_lane(input logic [WORD_W-1:0] word,
                                                    input byte_idx_t         idx);
        case (idx)
            2'd0:    return word[7:0];
            2'd1:    return word[15:8];
            2'd2:    return word[23:16];
            default: return word[31:24];
        endcase
    endfunction

endpackage

// File: rtl/ufm_shadow_byte_streamer_fifo.sv
// Two-entry 32-bit word buffer (ufm_word_fifo2) with simultaneous push/pop.
// Exposes the post-edge head and count so the caller can register outputs that track them.
module ufm_word_fifo2
    import ufm_shadow_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [WORD_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [1:0]        count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [1:0]        count_next_o,
    output logic [WORD_W-1:0] head_next_o
);

    logic [WORD_W-1:0] mem0_q, mem0_d;
    logic [WORD_W-1:0] mem1_q, mem1_d;
    logic [1:0]        count_q, count_d;

    // mem0 always holds the head word; mem1 the word behind it.
    always_comb begin
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        count_d = count_q;
        if (clr_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) mem0_d = push_data_i;
                    else                 mem1_d = push_data_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    mem0_d  = mem1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        mem0_d = push_data_i;
                    end else begin
                        mem0_d = mem1_q;
                        mem1_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign full_o       = (count_q == 2'd2);
    assign empty_o      = (count_q == 2'd0);
    assign count_next_o = count_d;
    assign head_next_o  = mem0_d;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push_i && !pop_i && !clr_i && (count_q == 2'd2)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(pop_i && !clr_i && (count_q == 2'd0)));

endmodule

// File: rtl/ufm_shadow_byte_streamer.sv
// Streams the shadowed UFM RAM as little-endian bytes with valid/ready handshake.
// Optional UFM_SHADOW_STREAM_CHECKSUM_EN adds checksum_o (16-bit sum of accepted bytes).
module ufm_shadow_byte_streamer
    import ufm_shadow_pkg::*;
#(
    parameter  int unsigned NUM_WORDS    = 512,
    parameter  int unsigned READ_LATENCY = 1,
    localparam int unsigned ADDR_W       = $clog2(NUM_WORDS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              copy_complete_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_rd_o,
    input  logic [WORD_W-1:0] ram_data_i,
    output logic [BYTE_W-1:0] byte_data_o,
    output logic              byte_valid_o,
    input  logic              byte_ready_i,
    output logic              byte_last_o,
    output logic              busy_o,
    output logic              done_o
`ifdef UFM_SHADOW_STREAM_CHECKSUM_EN
    ,
    output logic [CSUM_W-1:0] checksum_o
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned TOK_W = 3;

    state_e                  state_q, state_d;
    logic                    clr_c, hs_c, pop_c, push_c, issue_c;
    logic                    busy_q, busy_d, done_q, done_d;
    logic                    rd_q, rd_d, valid_q, valid_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d, issue_base_c;
    logic [ADDR_W-1:0]       head_idx_q, head_idx_d;
    byte_idx_t               byte_idx_q, byte_idx_d;
    logic [READ_LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [TOK_W-1:0]        tok_c;
    byte_beat_t              beat_q, beat_d;

    logic [1:0]              fifo_count, fifo_count_next;
    logic                    fifo_full, fifo_empty;
    logic [WORD_W-1:0]       fifo_head_next;

    assign hs_c   = valid_q && byte_ready_i;
    assign pop_c  = hs_c && !fifo_empty && (byte_idx_q == LAST_BYTE);
    assign push_c = vld_sr_q[READ_LATENCY-1];

    // Next-state and status flags.
    always_comb begin
        state_d = state_q;
        clr_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    clr_c   = 1'b1;
                    state_d = copy_complete_i ? ST_STREAM : ST_WAIT_COPY;
                end
            end
            ST_WAIT_COPY: if (copy_complete_i) state_d = ST_STREAM;
            ST_STREAM:    if (hs_c && beat_q.last) state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_WAIT_COPY) || (state_d == ST_STREAM);
        done_d = (state_d == ST_DONE) || (done_q && !clr_c);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Words buffered plus words still in the read pipeline; kept at or below two.
    always_comb begin
        tok_c = TOK_W'(fifo_count) + TOK_W'(rd_q);
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            tok_c = tok_c + TOK_W'(vld_sr_q[i]);
        end
        issue_base_c = clr_c ? '0 : issue_cnt_q;
        issue_c      = (state_d == ST_STREAM) && (issue_base_c < CNT_W'(NUM_WORDS)) &&
                       (tok_c < (TOK_W'(2) + TOK_W'(pop_c)));
        rd_d         = issue_c;
        addr_d       = issue_c ? issue_base_c[ADDR_W-1:0] : addr_q;
        issue_cnt_d  = issue_base_c + CNT_W'(issue_c);
        vld_sr_d     = '0;
        if (!clr_c) begin
            vld_sr_d[0] = rd_q;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                vld_sr_d[i] = vld_sr_q[i-1];
            end
        end
    end

    ufm_word_fifo2 u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr_i        (clr_c),
        .push_i       (push_c),
        .push_data_i  (ram_data_i),
        .pop_i        (pop_c),
        .count_o      (fifo_count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_next_o (fifo_count_next),
        .head_next_o  (fifo_head_next)
    );

    // Output beat is built from the post-edge head so it stays registered and stable while stalled.
    always_comb begin
        byte_idx_d  = byte_idx_q;
        head_idx_d  = head_idx_q;
        if (clr_c) begin
            byte_idx_d = '0;
            head_idx_d = '0;
        end else begin
            if (hs_c)  byte_idx_d = byte_idx_q + byte_idx_t'(1);
            if (pop_c) head_idx_d = head_idx_q + ADDR_W'(1);
        end
        valid_d     = (state_d == ST_STREAM) && (fifo_count_next != 2'd0);
        beat_d.data = valid_d ? word_lane(fifo_head_next, byte_idx_d) : '0;
        beat_d.last = valid_d && (head_idx_d == ADDR_W'(NUM_WORDS - 1)) &&
                      (byte_idx_d == LAST_BYTE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            head_idx_q  <= '0;
            byte_idx_q  <= '0;
            vld_sr_q    <= '0;
            valid_q     <= 1'b0;
            beat_q      <= '0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            head_idx_q  <= head_idx_d;
            byte_idx_q  <= byte_idx_d;
            vld_sr_q    <= vld_sr_d;
            valid_q     <= valid_d;
            beat_q      <= beat_d;
        end
    end

`ifdef UFM_SHADOW_STREAM_CHECKSUM_EN
    logic [CSUM_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (clr_c)     csum_d = '0;
        else if (hs_c) csum_d = csum_q + CSUM_W'(beat_q.data);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) csum_q <= '0;
        else          csum_q <= csum_d;
    end

    assign checksum_o = csum_q;
`endif

    assign ram_addr_o   = addr_q;
    assign ram_rd_o     = rd_q;
    assign byte_data_o  = beat_q.data;
    assign byte_valid_o = valid_q;
    assign byte_last_o  = beat_q.last;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

    a_issue_when_full: assert property (@(posedge clk) disable iff (!reset_n)
        !(issue_c && fifo_full && !pop_c));

endmodule

// File: doc/ufm_shadow_byte_streamer.md
Name: ufm_shadow_byte_streamer

Overview:
- Downstream consumer of the UFM-to-RAM shadow copy stage.
- After the shadow copy signals completion, on request it reads the shadowed RAM word by word and serialises each 32-bit word into a byte stream with valid/ready handshake.
- Feeds byte-oriented consumers (picture/palette loaders) at up to one byte per clock.
- Contains a two-entry word buffer so RAM read latency is hidden.

Parameters:
- num_words, 512, number of 32-bit words in the shadow RAM; num_addr_bits = $clog2(num_words).
- read_latency, 1, cycles from ram_rd_o high to ram_data_i valid; legal values 1 or 2.

Ports:
- clk  input  1  single clock.
- reset_n  input  1  asynchronous active-low reset.
- copy_complete_i  input  1  shadow copy finished; RAM contents are stable.
- start_i  input  1  single-cycle pulse requesting a full stream.
- ram_addr_o  output  num_addr_bits  RAM read word address.
- ram_rd_o  output  1  RAM read strobe, one word per high cycle.
- ram_data_i  input  32  RAM read data, valid read_latency cycles after the strobe.
- byte_data_o  output  8  stream byte.
- byte_valid_o  output  1  byte_data_o is valid.
- byte_ready_i  input  1  consumer accepts the byte when valid and ready are both high.
- byte_last_o  output  1  marks the final byte of the stream; qualified by byte_valid_o.
- busy_o  output  1  a stream is in progress.
- done_o  output  1  sticky: last byte accepted; cleared by the next accepted start_i.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; buffers empty; word/byte counters 0; read pipeline cleared. Reset mid-stream aborts immediately with no further RAM reads.
- FSM states:
  - IDLE: start_i high and copy_complete_i high -> STREAM; start_i high and copy_complete_i low -> WAIT_COPY. In both cases clear done_o, reset counters and buffers, set busy_o.
  - WAIT_COPY: stay until copy_complete_i high -> STREAM.
  - STREAM: issue reads and emit bytes. Exit when the last byte is accepted -> DONE.
  - DONE: set done_o, clear busy_o, then IDLE in the next cycle.
- start_i is ignored unless the FSM is in IDLE.
- copy_complete_i is sampled only on entry to STREAM. Deassertion during STREAM is ignored.
- Read issue rule: in STREAM, assert ram_rd_o for one cycle when (words buffered + reads in flight) < 2 and reads issued < num_words. ram_addr_o = issue counter. The issue counter increments on each strobe and never wraps past num_words-1.
- Read return: data is written into the word buffer exactly read_latency cycles after the strobe, tracked by a valid shift register of depth read_latency.
- Buffer overflow is impossible by the issue rule. Verification asserts this.
- Serialisation is little-endian: byte 0 = word[7:0], byte 3 = word[31:24].
- byte_valid_o is high whenever the head word is present.
- On handshake:
  - the byte index advances;
  - after byte 3 the head word is popped, and a word arriving in the same cycle is written correctly (simultaneous push and pop).
- While byte_valid_o is high and byte_ready_i is low, byte_data_o and byte_last_o hold stable.
- byte_last_o = head word index is num_words-1 and byte index is 3.
- Throughput: one byte per clock with byte_ready_i held high, after an initial latency of read_latency+1 cycles from entering STREAM to the first byte_valid_o.
- Total bytes per stream = 4*num_words. Address wrap is not permitted.

Optional Feature:
- Macro: UFM_SHADOW_STREAM_CHECKSUM_EN.
- When defined, adds output port checksum_o[15:0]:
  - the modulo-2^16 sum of all accepted bytes, each zero-extended;
  - cleared on accepted start_i;
  - valid while done_o is high.
- When undefined, the port and the adder are absent. Stream behaviour is identical in both builds.

Decomposition:
- Shared package ufm_shadow_pkg:
  - FSM state enum (IDLE, WAIT_COPY, STREAM, DONE);
  - BYTES_PER_WORD = 4;
  - the byte-lane index typedef.
- One natural sub-module: ufm_word_fifo2, a two-entry 32-bit word buffer with simultaneous push/pop, count output, and full/empty flags.

Test Plan:
- num_words=4, read_latency=1, copy_complete_i high, start pulse, ready always high; RAM word k = 0x03020100 + k*0x04040404 -> bytes 0x00..0x0F on 16 consecutive cycles. First valid arrives 2 cycles after STREAM entry. byte_last_o is high only with 0x0F. done_o sets and busy_o clears.
- start while copy_complete_i low, raise it 10 cycles later -> no ram_rd_o before the rise; stream then runs as in the first test.
- read_latency=2, byte_ready_i toggling 1,0,0,1 -> byte_data_o stable while stalled. Sequence and count are unchanged. Never more than 2 words buffered or in flight.
- start_i pulsed during STREAM -> ignored. Reset_n asserted after byte 6 -> all outputs 0 on the next edge. A fresh start then restarts from address 0.
- UFM_SHADOW_STREAM_CHECKSUM_EN defined, data as in the first test -> checksum_o = 0x0078 (sum of 0..15 = 120) while done_o is high.
- num_words=512 full run -> ram_addr_o covers 0..511 exactly once, 2048 bytes are emitted, and byte_last_o is high on the final byte only.
